// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, memory and status signals of the data memory arbiter
// The arbiter takes the slave view; requesters and the memory take the master view.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              core_stall;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic [15:0]       conflicts;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  rd_data,
        output c_gnt, c_rvalid, c_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output core_stall, wr, rd, addr, wr_data, conflicts
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output rd_data,
        input  c_gnt, c_rvalid, c_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  core_stall, wr, rd, addr, wr_data, conflicts
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter between core and debug requesters for one data memory port
// Grants are combinational; the memory command is registered; read data returns two cycles after grant.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     bus
);

    logic              w_both;
    logic              w_c_gnt;
    logic              w_d_gnt;
    logic              w_any_gnt;
    logic              w_gnt_we;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic              w_c_rvalid;
    logic              w_d_rvalid;

    // r_prio_d = 1 means the debug requester wins the next tie (core was granted last)
    logic              r_prio_d;
    logic              r_wr;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_v1;
    logic              r_o1;
    logic              r_v2;
    logic              r_o2;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [15:0]       r_conflicts;

    always_comb begin
        w_both      = bus.c_req & bus.d_req;
        w_c_gnt     = ~reset & bus.c_req & (~bus.d_req | ~r_prio_d);
        w_d_gnt     = ~reset & bus.d_req & (~bus.c_req |  r_prio_d);
        w_any_gnt   = w_c_gnt | w_d_gnt;
        w_gnt_we    = w_d_gnt ? bus.d_we    : bus.c_we;
        w_gnt_addr  = w_d_gnt ? bus.d_addr  : bus.c_addr;
        w_gnt_wdata = w_d_gnt ? bus.d_wdata : bus.c_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio_d <= 1'b0;
        end else if (w_c_gnt) begin
            r_prio_d <= 1'b1;
        end else if (w_d_gnt) begin
            r_prio_d <= 1'b0;
        end
    end

    // Memory command stage: strobes last one cycle, address/data hold between grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_wr <= w_any_gnt &  w_gnt_we;
            r_rd <= w_any_gnt & ~w_gnt_we;
            if (w_any_gnt) begin
                r_addr  <= w_gnt_addr;
                r_wdata <= w_gnt_wdata;
            end
        end
    end

    // Owner pipeline: stage 1 aligns with rd, stage 2 aligns with rd_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_o1 <= 1'b0;
            r_v2 <= 1'b0;
            r_o2 <= 1'b0;
        end else begin
            r_v1 <= w_any_gnt & ~w_gnt_we;
            r_o1 <= w_d_gnt;
            r_v2 <= r_v1;
            r_o2 <= r_o1;
        end
    end

    always_comb begin
        w_c_rvalid = r_v2 & ~r_o2;
        w_d_rvalid = r_v2 &  r_o2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_c_rvalid) begin
                r_c_rdata <= bus.rd_data;
            end
            if (w_d_rvalid) begin
                r_d_rdata <= bus.rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflicts <= 16'h0000;
        end else if (w_both && (r_conflicts != 16'hFFFF)) begin
            r_conflicts <= r_conflicts + 16'h0001;
        end
    end

    assign bus.c_gnt      = w_c_gnt;
    assign bus.d_gnt      = w_d_gnt;
    assign bus.core_stall = bus.c_req & ~w_c_gnt;
    assign bus.c_rvalid   = w_c_rvalid;
    assign bus.d_rvalid   = w_d_rvalid;
    assign bus.c_rdata    = w_c_rvalid ? bus.rd_data : r_c_rdata;
    assign bus.d_rdata    = w_d_rvalid ? bus.rd_data : r_d_rdata;
    assign bus.wr         = r_wr;
    assign bus.rd         = r_rd;
    assign bus.addr       = r_addr;
    assign bus.wr_data    = r_wdata;
    assign bus.conflicts  = r_conflicts;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a one-cycle-latency memory model
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    bit [31:0]  mem [512];
    bit [511:0] wmask;
    logic [31:0] m_rdata;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(9)) bus ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] preset(input logic [8:0] a);
        case (a)
            9'h010:  preset = 32'hDEADBEEF;
            9'h001:  preset = 32'h00000011;
            9'h002:  preset = 32'h00000022;
            9'h007:  preset = 32'h00000077;
            default: preset = {23'h0, a} ^ 32'h5A5A0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.wr) begin
            mem[bus.addr]   <= bus.wr_data;
            wmask[bus.addr] <= 1'b1;
        end
        if (bus.rd) begin
            m_rdata <= wmask[bus.addr] ? mem[bus.addr] : preset(bus.addr);
        end
    end
    assign bus.rd_data = m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_c(input logic req, input logic we, input logic [8:0] a, input logic [31:0] wd);
        bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [8:0] a, input logic [31:0] wd);
        bus.d_req = req; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        set_c(0, 0, 9'h0, 32'h0);
        set_d(0, 0, 9'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        set_c(0, 0, 9'h0, 32'h0);
        set_d(0, 0, 9'h0, 32'h0);

        // reset state, with a request held during reset
        repeat (2) @(negedge clk);
        set_c(1, 0, 9'h010, 32'h0);
        #1;
        chk("rst_c_gnt",    32'(bus.c_gnt), 32'h0);
        chk("rst_wr_rd",    32'({bus.wr, bus.rd}), 32'h0);
        chk("rst_addr",     32'(bus.addr), 32'h0);
        chk("rst_rvalid",   32'({bus.c_rvalid, bus.d_rvalid}), 32'h0);
        chk("rst_c_rdata",  bus.c_rdata, 32'h0);
        chk("rst_conflict", 32'(bus.conflicts), 32'h0);

        // core-only read, granted in the first cycle after reset
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("cr_c_gnt", 32'(bus.c_gnt), 32'h1);
        chk("cr_d_gnt", 32'(bus.d_gnt), 32'h0);
        chk("cr_stall", 32'(bus.core_stall), 32'h0);
        @(negedge clk);
        set_c(0, 0, 9'h0, 32'h0);
        #1;
        chk("cr_rd",     32'({bus.wr, bus.rd}), 32'h1);
        chk("cr_addr",   32'(bus.addr), 32'h010);
        chk("cr_early",  32'({bus.c_rvalid, bus.d_rvalid}), 32'h0);
        @(negedge clk);
        #1;
        chk("cr_rvalid", 32'({bus.c_rvalid, bus.d_rvalid}), 32'h2);
        chk("cr_rdata",  bus.c_rdata, 32'hDEADBEEF);
        chk("cr_rd_off", 32'(bus.rd), 32'h0);
        chk("cr_addr_hold", 32'(bus.addr), 32'h010);
        @(negedge clk);
        #1;
        chk("cr_rvalid_off", 32'({bus.c_rvalid, bus.d_rvalid}), 32'h0);
        chk("cr_rdata_hold", bus.c_rdata, 32'hDEADBEEF);

        // continuous contention from reset: C, D, C, D
        pulse_reset();
        set_c(1, 0, 9'h003, 32'h0);
        set_d(1, 0, 9'h004, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_c_gnt", 32'(bus.c_gnt), 32'(i % 2 == 0));
            chk("rr_d_gnt", 32'(bus.d_gnt), 32'(i % 2 == 1));
            chk("rr_stall", 32'(bus.core_stall), 32'(i % 2 == 1));
            @(negedge clk);
        end
        set_c(0, 0, 9'h0, 32'h0);
        set_d(0, 0, 9'h0, 32'h0);
        #1;
        chk("rr_conflicts", 32'(bus.conflicts), 32'd4);
        repeat (3) @(negedge clk);

        // back-to-back reads with different owners
        set_c(1, 0, 9'h001, 32'h0);
        #1;
        chk("bb_c_gnt", 32'(bus.c_gnt), 32'h1);
        @(negedge clk);
        set_c(0, 0, 9'h0, 32'h0);
        set_d(1, 0, 9'h002, 32'h0);
        #1;
        chk("bb_d_gnt", 32'(bus.d_gnt), 32'h1);
        @(negedge clk);
        set_d(0, 0, 9'h0, 32'h0);
        #1;
        chk("bb_c_rvalid", 32'({bus.c_rvalid, bus.d_rvalid}), 32'h2);
        chk("bb_c_rdata",  bus.c_rdata, 32'h00000011);
        @(negedge clk);
        #1;
        chk("bb_d_rvalid", 32'({bus.c_rvalid, bus.d_rvalid}), 32'h1);
        chk("bb_d_rdata",  bus.d_rdata, 32'h00000022);
        chk("bb_c_hold",   bus.c_rdata, 32'h00000011);

        // debug write then core read of the same word
        @(negedge clk);
        set_d(1, 1, 9'h005, 32'hCAFE0001);
        #1;
        chk("wr_d_gnt", 32'(bus.d_gnt), 32'h1);
        @(negedge clk);
        set_d(0, 0, 9'h0, 32'h0);
        set_c(1, 0, 9'h005, 32'h0);
        #1;
        chk("wr_strobe", 32'({bus.wr, bus.rd}), 32'h2);
        chk("wr_data",   bus.wr_data, 32'hCAFE0001);
        chk("wr_no_rv",  32'({bus.c_rvalid, bus.d_rvalid}), 32'h0);
        @(negedge clk);
        set_c(0, 0, 9'h0, 32'h0);
        #1;
        chk("wr_rd_strobe", 32'({bus.wr, bus.rd}), 32'h1);
        chk("wr_rd_addr",   32'(bus.addr), 32'h005);
        chk("wr_no_rv2",    32'({bus.c_rvalid, bus.d_rvalid}), 32'h0);
        @(negedge clk);
        #1;
        chk("wr_readback", bus.c_rdata, 32'hCAFE0001);

        // read then write to the same word returns pre-write data
        @(negedge clk);
        set_c(1, 0, 9'h007, 32'h0);
        @(negedge clk);
        set_c(0, 0, 9'h0, 32'h0);
        set_d(1, 1, 9'h007, 32'h00000099);
        #1;
        chk("raw_d_gnt", 32'(bus.d_gnt), 32'h1);
        @(negedge clk);
        set_d(0, 0, 9'h0, 32'h0);
        #1;
        chk("raw_rvalid", 32'(bus.c_rvalid), 32'h1);
        chk("raw_rdata",  bus.c_rdata, 32'h00000077);

        // reset in the cycle after a read grant discards the read
        @(negedge clk);
        set_c(1, 0, 9'h010, 32'h0);
        #1;
        chk("ab_c_gnt", 32'(bus.c_gnt), 32'h1);
        @(negedge clk);
        set_c(0, 0, 9'h0, 32'h0);
        rst = 1'b1;
        #1;
        chk("ab_rd_cleared", 32'(bus.rd), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ab_rvalid",  32'({bus.c_rvalid, bus.d_rvalid}), 32'h0);
            chk("ab_strobes", 32'({bus.wr, bus.rd}), 32'h0);
            @(negedge clk);
        end
        chk("ab_addr",      32'(bus.addr), 32'h0);
        chk("ab_c_rdata",   bus.c_rdata, 32'h0);
        chk("ab_conflicts", 32'(bus.conflicts), 32'h0);

        // long contention: counter saturates without wrapping
        pulse_reset();
        set_c(1, 0, 9'h020, 32'h0);
        set_d(1, 0, 9'h021, 32'h0);
        repeat (65534) @(negedge clk);
        #1;
        chk("sat_pre", 32'(bus.conflicts), 32'h0000FFFE);
        repeat (70000 - 65534) @(negedge clk);
        #1;
        chk("sat_final", 32'(bus.conflicts), 32'h0000FFFF);
        set_c(0, 0, 9'h0, 32'h0);
        set_d(0, 0, 9'h0, 32'h0);
        @(negedge clk);
        #1;
        chk("sat_hold", 32'(bus.conflicts), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 9, data memory word address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports c_req / c_we  input  1 each  core request valid / write (1) or read (0).
REQ-006 SHALL have ports c_addr  input  ADDR_W  and  c_wdata  input  DATA_W  core address and write data.
REQ-007 SHALL have ports c_gnt / c_rvalid  output  1 each  core request accepted / core read data valid.
REQ-008 SHALL have port c_rdata  output  DATA_W  core read data.
REQ-009 SHALL have ports d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, identical to REQ-005..008, for the debug/loader requester.
REQ-010 SHALL have port core_stall  output  1  equal to c_req & ~c_gnt (combinational).
REQ-011 SHALL have ports wr / rd  output  1 each  memory write / read strobes.
REQ-012 SHALL have ports addr  output  ADDR_W  and  wr_data  output  DATA_W  memory command.
REQ-013 SHALL have port rd_data  input  DATA_W  memory read data, valid exactly one cycle after rd.
REQ-014 SHALL have port conflicts  output  16  count of contention cycles.

Function
REQ-015 Grant SHALL be combinational in the request cycle; at most one of c_gnt, d_gnt SHALL be high per cycle.
REQ-016 With a single requester active, that requester SHALL be granted every cycle it requests.
REQ-017 When both request in the same cycle, the winner SHALL be chosen round-robin: the requester not granted most recently wins; after reset the core has priority.
REQ-018 The round-robin pointer SHALL update only in cycles with a grant, recording the granted requester.
REQ-019 A grant in cycle N SHALL drive wr=we, rd=~we, addr and wr_data from the granted requester, registered, during cycle N+1 only.
REQ-020 In cycles N+1 with no grant in N, wr and rd SHALL be 0; addr and wr_data SHALL hold their last values.
REQ-021 For a read granted in N, the owner's rvalid SHALL be 1 in cycle N+2 only, with its rdata = rd_data in N+2; the other requester's rvalid SHALL be 0.
REQ-022 Owner tracking SHALL be a two-stage (valid, owner) pipeline so back-to-back grants in consecutive cycles, including alternating owners, return data in order at one per cycle.
REQ-023 Writes SHALL produce no rvalid.
REQ-024 c_rdata and d_rdata SHALL be driven from rd_data whenever the owner's rvalid is high and hold their last value otherwise.
REQ-025 Requesters SHALL hold req and payload stable until granted; the block SHALL not queue or buffer ungranted requests.
REQ-026 conflicts SHALL increment by 1 in each cycle where c_req & d_req, saturating at 16'hFFFF.
REQ-027 A read followed in the next cycle by a write to the same address SHALL return pre-write data (memory order = grant order).

Reset
REQ-028 While reset is high: c_gnt, d_gnt, c_rvalid, d_rvalid, wr, rd = 0; addr, wr_data, c_rdata, d_rdata = 0; conflicts = 0; round-robin pointer = core priority; owner pipeline invalid.
REQ-029 Reset asserted mid-operation SHALL discard in-flight reads: no rvalid SHALL assert for any grant issued before reset deassertion.
REQ-030 First grant SHALL be possible in the first clock cycle after reset deassertion.

Verification
REQ-031 Core-only read, c_addr=9'h010, memory returns 32'hDEADBEEF -> c_gnt in N, rd=1/addr=9'h010 in N+1, c_rvalid=1/c_rdata=32'hDEADBEEF in N+2, d_rvalid=0 throughout.
REQ-032 Both request continuously for 4 cycles from reset -> grants C,D,C,D; core_stall=1 in cycles 2 and 4; conflicts=4.
REQ-033 Back-to-back reads core addr 1 then debug addr 2, memory returns 32'h11, 32'h22 -> c_rvalid with 32'h11 in N+2, d_rvalid with 32'h22 in N+3.
REQ-034 Debug write 9'h005=32'hCAFE0001 then core read 9'h005 -> wr=1 in N+1, rd=1 in N+2, c_rdata=32'hCAFE0001 in N+3.
REQ-035 Core read granted, reset pulsed in the following cycle -> no c_rvalid afterwards, all outputs 0, conflicts=0.
REQ-036 Force contention for 70000 cycles -> conflicts stops at 16'hFFFF and does not wrap.
